// File: rtl/hazard_controller_if.sv
// Hazard controller bundle: ID/EX/MEM status in, pipeline control and
// event counters out.
interface hazard_controller_if;
    logic [15:0] id_instruction;
    logic        id_valid;
    logic        ex_MemRead;
    logic [2:0]  ex_rt;
    logic        mem_branch_taken;
    logic        mem_busy;
    logic        pc_write;
    logic        ifid_write;
    logic        idex_bubble;
    logic        pipe_hold;
    logic        ifid_flush;
    logic        idex_flush;
    logic        exmem_flush;
    logic [1:0]  state;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    modport master (
        output id_instruction, id_valid, ex_MemRead, ex_rt,
        output mem_branch_taken, mem_busy,
        input  pc_write, ifid_write, idex_bubble, pipe_hold,
        input  ifid_flush, idex_flush, exmem_flush,
        input  state, stall_count, flush_count
    );

    modport slave (
        input  id_instruction, id_valid, ex_MemRead, ex_rt,
        input  mem_branch_taken, mem_busy,
        output pc_write, ifid_write, idex_bubble, pipe_hold,
        output ifid_flush, idex_flush, exmem_flush,
        output state, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_controller.sv
// Load-use stall, memory-wait hold and taken-branch flush control
// for a 5-stage pipeline, with saturating stall/flush counters.
module hazard_controller #(
    parameter int         LOAD_STALL_CYCLES = 1,
    parameter logic [7:0] RT_SRC_MASK       = 8'b0001_1001
) (
    input logic clk,
    input logic reset_n,
    hazard_controller_if.slave hz
);
    typedef enum logic [1:0] {
        RUN    = 2'b00,
        LSTALL = 2'b01,
        MWAIT  = 2'b10
    } state_e;

    localparam logic [1:0] LOAD_CNT = 2'(LOAD_STALL_CYCLES - 1);
    localparam bit         MULTI    = (LOAD_STALL_CYCLES > 1);

    state_e      state_q, state_n;
    state_e      ret_q, ret_n;
    state_e      eff_state;
    logic [1:0]  cnt_q, cnt_n;
    logic [15:0] stall_q, flush_q;
    logic [2:0]  opcode, rs, rt;
    logic        hazard;
    logic        pc_write, ifid_write, idex_bubble, pipe_hold, flush;
    logic        unused_bits;

    assign opcode      = hz.id_instruction[15:13];
    assign rs          = hz.id_instruction[12:10];
    assign rt          = hz.id_instruction[9:7];
    assign unused_bits = ^hz.id_instruction[6:0];

    assign hazard = hz.id_valid & hz.ex_MemRead &
                    ((hz.ex_rt == rs) |
                     (RT_SRC_MASK[opcode] & (hz.ex_rt == rt)));

    // After a memory wait, resume whatever state was interrupted.
    assign eff_state = (state_q == MWAIT) ? ret_q : state_q;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        flush       = 1'b0;
        state_n     = state_q;
        ret_n       = ret_q;
        cnt_n       = cnt_q;
        if (!reset_n) begin
            state_n = RUN;
        end else if (hz.mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
            state_n    = MWAIT;
            if (state_q != MWAIT)
                ret_n = state_q;
        end else if (hz.mem_branch_taken) begin
            flush   = 1'b1;
            state_n = RUN;
            ret_n   = RUN;
            cnt_n   = 2'd0;
        end else if (eff_state == LSTALL) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            cnt_n       = cnt_q - 2'd1;
            state_n     = (cnt_q == 2'd1) ? RUN : LSTALL;
        end else if (hazard) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            if (MULTI) begin
                state_n = LSTALL;
                cnt_n   = LOAD_CNT;
            end else begin
                state_n = RUN;
            end
        end else begin
            state_n = RUN;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            ret_q   <= RUN;
            cnt_q   <= 2'd0;
            stall_q <= 16'd0;
            flush_q <= 16'd0;
        end else begin
            state_q <= state_n;
            ret_q   <= ret_n;
            cnt_q   <= cnt_n;
            if (!pc_write && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'd1;
            if (flush && flush_q != 16'hFFFF)
                flush_q <= flush_q + 16'd1;
        end
    end

    assign hz.pc_write    = pc_write;
    assign hz.ifid_write  = ifid_write;
    assign hz.idex_bubble = idex_bubble;
    assign hz.pipe_hold   = pipe_hold;
    assign hz.ifid_flush  = flush;
    assign hz.idex_flush  = flush;
    assign hz.exmem_flush = flush;
    assign hz.state       = state_q;
    assign hz.stall_count = stall_q;
    assign hz.flush_count = flush_q;
endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: vector table on a 1-bubble
// instance plus multi-cycle sequences on a 3-bubble instance.
module tb_hazard_controller;
    typedef struct packed {
        logic [15:0] instr;
        logic        valid;
        logic        mr;
        logic [2:0]  ex_rt;
        logic        br;
        logic        busy;
    } in_t;

    typedef struct {
        in_t        in;
        logic [6:0] exp_o;
        logic [1:0] exp_s;
    } vec_t;

    // {pc_write, ifid_write, idex_bubble, pipe_hold, ifid/idex/exmem flush}
    localparam logic [6:0] O_DEF = 7'b1100000;
    localparam logic [6:0] O_STL = 7'b0010000;
    localparam logic [6:0] O_HLD = 7'b0001000;
    localparam logic [6:0] O_FLS = 7'b1100111;

    logic clk = 1'b0;
    logic reset_n;
    int   n_chk = 0;
    int   n_fail = 0;
    in_t  in_a, in_b;
    in_t  idle_in, haz_in;
    vec_t tbl [16];
    logic [6:0] ov_a, ov_b;

    always #5 clk = ~clk;

    hazard_controller_if a ();
    hazard_controller_if b ();

    assign a.id_instruction   = in_a.instr;
    assign a.id_valid         = in_a.valid;
    assign a.ex_MemRead       = in_a.mr;
    assign a.ex_rt            = in_a.ex_rt;
    assign a.mem_branch_taken = in_a.br;
    assign a.mem_busy         = in_a.busy;
    assign b.id_instruction   = in_b.instr;
    assign b.id_valid         = in_b.valid;
    assign b.ex_MemRead       = in_b.mr;
    assign b.ex_rt            = in_b.ex_rt;
    assign b.mem_branch_taken = in_b.br;
    assign b.mem_busy         = in_b.busy;

    assign ov_a = {a.pc_write, a.ifid_write, a.idex_bubble, a.pipe_hold,
                   a.ifid_flush, a.idex_flush, a.exmem_flush};
    assign ov_b = {b.pc_write, b.ifid_write, b.idex_bubble, b.pipe_hold,
                   b.ifid_flush, b.idex_flush, b.exmem_flush};

    hazard_controller #(.LOAD_STALL_CYCLES(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .hz(a)
    );
    hazard_controller #(.LOAD_STALL_CYCLES(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .hz(b)
    );

    function automatic in_t mk(input logic [2:0] op, input logic [2:0] rs,
                               input logic [2:0] rt, input logic valid,
                               input logic mr, input logic [2:0] ert,
                               input logic br, input logic busy);
        in_t r;
        r.instr = {op, rs, rt, 7'b0};
        r.valid = valid;
        r.mr    = mr;
        r.ex_rt = ert;
        r.br    = br;
        r.busy  = busy;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        in_a    = idle_in;
        in_b    = idle_in;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        idle_in = mk(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        // LW r3 in EX, ADD with rs=r3 in ID
        haz_in  = mk(3'd0, 3'd3, 3'd1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);

        tbl[0]  = '{mk(0,3,1,1,0,3,0,0), O_DEF, 2'd0};
        tbl[1]  = '{mk(0,3,1,1,1,3,0,0), O_STL, 2'd0};
        tbl[2]  = '{mk(0,1,3,1,1,3,0,0), O_STL, 2'd0};
        tbl[3]  = '{mk(1,5,2,1,1,2,0,0), O_DEF, 2'd0};
        tbl[4]  = '{mk(3,5,2,1,1,2,0,0), O_STL, 2'd0};
        tbl[5]  = '{mk(4,5,2,1,1,2,0,0), O_STL, 2'd0};
        tbl[6]  = '{mk(2,1,4,1,1,4,0,0), O_DEF, 2'd0};
        tbl[7]  = '{mk(0,0,5,1,1,0,0,0), O_STL, 2'd0};
        tbl[8]  = '{mk(0,3,3,0,1,3,0,0), O_DEF, 2'd0};
        tbl[9]  = '{mk(0,3,1,1,1,3,0,1), O_HLD, 2'd0};
        tbl[10] = '{mk(0,3,1,1,1,3,0,1), O_HLD, 2'd2};
        tbl[11] = '{mk(0,3,1,1,0,3,0,0), O_DEF, 2'd2};
        tbl[12] = '{mk(0,3,1,1,1,3,1,0), O_FLS, 2'd0};
        tbl[13] = '{mk(0,0,0,1,0,0,1,1), O_HLD, 2'd0};
        tbl[14] = '{mk(0,0,0,1,0,0,1,0), O_FLS, 2'd2};
        tbl[15] = '{mk(0,6,1,1,1,6,0,0), O_STL, 2'd0};

        do_reset();
        #1;
        chk("reset_out", 32'(ov_a), 32'(O_DEF));
        chk("reset_state", 32'(a.state), 32'd0);
        chk("reset_stall_cnt", 32'(a.stall_count), 32'd0);
        chk("reset_flush_cnt", 32'(a.flush_count), 32'd0);

        for (int i = 0; i < 16; i++) begin
            in_a = tbl[i].in;
            #1;
            chk($sformatf("vec%0d_out", i), 32'(ov_a), 32'(tbl[i].exp_o));
            chk($sformatf("vec%0d_state", i), 32'(a.state), 32'(tbl[i].exp_s));
            tick();
        end
        in_a = idle_in;
        #1;
        chk("tbl_stall_cnt", 32'(a.stall_count), 32'd9);
        chk("tbl_flush_cnt", 32'(a.flush_count), 32'd2);

        // single bubble, then EX holds the bubble
        do_reset();
        in_a = haz_in;
        #1;
        chk("s1_stall", 32'(ov_a), 32'(O_STL));
        tick();
        in_a = mk(0,3,1,1,0,3,0,0);
        #1;
        chk("s1_resume", 32'(ov_a), 32'(O_DEF));
        tick();
        chk("s1_stall_cnt", 32'(a.stall_count), 32'd1);

        // three bubbles, hazard held throughout
        do_reset();
        in_b = haz_in;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("s2_out%0d", k), 32'(ov_b), 32'(O_STL));
            chk($sformatf("s2_state%0d", k), 32'(b.state), (k == 0) ? 32'd0 : 32'd1);
            tick();
        end
        in_b = idle_in;
        #1;
        chk("s2_done_out", 32'(ov_b), 32'(O_DEF));
        chk("s2_done_state", 32'(b.state), 32'd0);
        chk("s2_stall_cnt", 32'(b.stall_count), 32'd3);

        // memory busy for 4 cycles in the 2nd bubble
        do_reset();
        in_b = haz_in;
        #1;
        chk("s3_first", 32'(ov_b), 32'(O_STL));
        tick();
        in_b = mk(0,3,1,1,1,3,0,1);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("s3_hold%0d", k), 32'(ov_b), 32'(O_HLD));
            chk($sformatf("s3_hstate%0d", k), 32'(b.state), (k == 0) ? 32'd1 : 32'd2);
            tick();
        end
        in_b = mk(0,3,1,1,0,3,0,0);
        #1;
        chk("s3_b2", 32'(ov_b), 32'(O_STL));
        chk("s3_b2_state", 32'(b.state), 32'd2);
        tick();
        #1;
        chk("s3_b3", 32'(ov_b), 32'(O_STL));
        chk("s3_b3_state", 32'(b.state), 32'd1);
        tick();
        #1;
        chk("s3_done", 32'(ov_b), 32'(O_DEF));
        chk("s3_done_state", 32'(b.state), 32'd0);
        chk("s3_stall_cnt", 32'(b.stall_count), 32'd7);

        // branch beats hazard, and aborts a stall in progress
        do_reset();
        in_b = mk(0,3,1,1,1,3,1,0);
        #1;
        chk("s4_flush", 32'(ov_b), 32'(O_FLS));
        tick();
        in_b = idle_in;
        #1;
        chk("s4_state", 32'(b.state), 32'd0);
        chk("s4_flush_cnt", 32'(b.flush_count), 32'd1);
        in_b = haz_in;
        #1;
        chk("s4_stall", 32'(ov_b), 32'(O_STL));
        tick();
        in_b = mk(0,3,1,1,1,3,1,0);
        #1;
        chk("s4_abort", 32'(ov_b), 32'(O_FLS));
        chk("s4_abort_state", 32'(b.state), 32'd1);
        tick();
        in_b = idle_in;
        #1;
        chk("s4_after", 32'(ov_b), 32'(O_DEF));
        chk("s4_after_state", 32'(b.state), 32'd0);
        chk("s4_flush_cnt2", 32'(b.flush_count), 32'd2);

        // taken branch waits for memory
        do_reset();
        in_a = mk(0,0,0,1,0,0,1,1);
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("s5_hold%0d", k), 32'(ov_a), 32'(O_HLD));
            tick();
        end
        in_a = mk(0,0,0,1,0,0,1,0);
        #1;
        chk("s5_flush", 32'(ov_a), 32'(O_FLS));
        tick();
        in_a = idle_in;
        #1;
        chk("s5_flush_cnt", 32'(a.flush_count), 32'd1);
        chk("s5_state", 32'(a.state), 32'd0);

        // stall counter saturation
        do_reset();
        in_a = haz_in;
        repeat (65534) tick();
        chk("s6_cnt_fffe", 32'(a.stall_count), 32'h0000FFFE);
        repeat (6) tick();
        chk("s6_cnt_sat", 32'(a.stall_count), 32'h0000FFFF);
        in_a = idle_in;
        tick();
        chk("s6_cnt_hold", 32'(a.stall_count), 32'h0000FFFF);

        // reset in the middle of a multi-bubble stall
        do_reset();
        in_b = haz_in;
        tick();
        #1;
        chk("s7_in_lstall", 32'(b.state), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("s7_rst_out", 32'(ov_b), 32'(O_DEF));
        chk("s7_rst_state", 32'(b.state), 32'd0);
        chk("s7_rst_cnt", 32'(b.stall_count), 32'd0);
        #1;
        reset_n = 1'b1;
        in_b = idle_in;
        tick();
        #1;
        chk("s7_post_out", 32'(ov_b), 32'(O_DEF));
        chk("s7_post_state", 32'(b.state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
